// File: rtl/ctr_pkt_pkg.sv
// Shared types and constants for the counter packet writer.
package ctr_pkt_pkg;

  // Packet writer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_DATA    = 2'd2,
    ST_TRAILER = 2'd3
  } state_e;

  // Default upper half of every header word.
  localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hA5C3;

endpackage

// File: rtl/ctr_pkt_writer.sv
// Counter packet writer: on start, emits a header word, pkt_len words taken
// from an upstream free-running counter, and a trailer holding the XOR of the
// data words. Writes stall on fifo_full without losing or duplicating words.
//
// Handshake: a word is transferred in any cycle where the FSM is not IDLE and
// fifo_full is low; fifo_wr_en marks exactly those cycles, and ctr_en asks the
// upstream counter to advance only after a data word has been transferred.
module ctr_pkt_writer
  import ctr_pkt_pkg::*;
#(
  parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEFAULT,
  parameter int          LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic [31:0]      ctr_val,
  output logic             ctr_en,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [31:0]      fifo_din,
  output logic             busy,
  output logic [15:0]      seq
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   cnt_inc;
  logic [31:0]        csum_q, csum_d;
  logic [15:0]        seq_q, seq_d;
  logic               wr_cycle;

  assign wr_cycle   = (state_q != ST_IDLE) && !fifo_full;
  assign fifo_wr_en = wr_cycle;
  assign busy       = (state_q != ST_IDLE);
  assign seq        = seq_q;
  assign cnt_inc    = cnt_q + LEN_W'(1);

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      seq_q   <= seq_d;
    end
  end

  // Next-state, datapath updates and per-state output word mux.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    seq_d    = seq_q;
    fifo_din = 32'h0;
    ctr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = pkt_len;
          cnt_d   = '0;
          csum_d  = 32'h0;
          state_d = ST_HEADER;
        end
      end
      ST_HEADER: begin
        fifo_din = {HDR_MAGIC, seq_q};
        if (wr_cycle) begin
          state_d = (len_q != '0) ? ST_DATA : ST_TRAILER;
        end
      end
      ST_DATA: begin
        fifo_din = ctr_val;
        ctr_en   = !fifo_full;
        if (wr_cycle) begin
          csum_d = csum_q ^ ctr_val;
          cnt_d  = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = ST_TRAILER;
          end
        end
      end
      ST_TRAILER: begin
        fifo_din = csum_q;
        if (wr_cycle) begin
          seq_d   = seq_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ctr_pkt_writer.sv
// Testbench for ctr_pkt_writer: models the upstream counter, drives packets
// with directed and randomized lengths / backpressure, and checks every
// written word against a packet list built from the packet format rules.
module tb_ctr_pkt_writer;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] pkt_len;
  logic [31:0]      ctr_val;
  logic             ctr_en;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [31:0]      fifo_din;
  logic             busy;
  logic [15:0]      seq;

  logic             ctr_load;
  logic [31:0]      ctr_load_val;

  int               n_assert = 0;
  int               n_fail   = 0;
  logic [31:0]      exp_q[$];
  logic [31:0]      exp_ctr;
  logic [15:0]      exp_seq;

  ctr_pkt_writer #(.HDR_MAGIC(16'hA5C3), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pkt_len    (pkt_len),
    .ctr_val    (ctr_val),
    .ctr_en     (ctr_en),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .busy       (busy),
    .seq        (seq)
  );

  // Clock.
  always #5 clk = ~clk;

  // Upstream free-running counter, advanced by ctr_en, loadable by the bench.
  always @(posedge clk) begin
    if (ctr_load) ctr_val <= ctr_load_val;
    else if (ctr_en) ctr_val <= ctr_val + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_ctr(input logic [31:0] v);
    @(negedge clk);
    ctr_load     = 1'b1;
    ctr_load_val = v;
    @(negedge clk);
    ctr_load = 1'b0;
    exp_ctr  = v;
  endtask

  // full_mode: 0 = never full, 1 = random backpressure,
  //            2 = full for 2 cycles right after the first data word.
  task automatic run_packet(input int len, input int full_mode, input bit mid_start);
    logic [31:0] x;
    int          idx;
    int          busy_cyc;
    int          full_run;
    bit          last_done;
    exp_q.delete();
    exp_q.push_back({16'hA5C3, exp_seq});
    x = 32'h0;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(exp_ctr + 32'(i));
      x = x ^ (exp_ctr + 32'(i));
    end
    exp_q.push_back(x);
    check("seq_before", {16'h0, seq}, {16'h0, exp_seq});

    @(negedge clk);
    start     = 1'b1;
    pkt_len   = LEN_W'(len);
    fifo_full = 1'b0;
    idx       = 0;
    busy_cyc  = 0;
    full_run  = 0;
    last_done = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      pkt_len = LEN_W'($urandom);
      start   = (mid_start && !last_done) ? 1'($urandom_range(0, 1)) : 1'b0;
      case (full_mode)
        1: fifo_full = ($urandom_range(0, 2) == 0) && !last_done;
        2: begin
          if (idx == 2 && full_run < 2) begin
            fifo_full = 1'b1;
            full_run++;
          end else begin
            fifo_full = 1'b0;
          end
        end
        default: fifo_full = 1'b0;
      endcase
      #1;
      if (last_done) begin
        check("idle_after_trailer", {31'h0, busy}, 32'h0);
        break;
      end
      busy_cyc++;
      check("busy", {31'h0, busy}, 32'h1);
      check("wr_en", {31'h0, fifo_wr_en}, {31'h0, !fifo_full});
      check("ctr_en", {31'h0, ctr_en}, {31'h0, (!fifo_full && idx >= 1 && idx <= len)});
      if (fifo_wr_en && exp_q.size() != 0) begin
        check("word", fifo_din, exp_q.pop_front());
        idx++;
        if (exp_q.size() == 0) last_done = 1'b1;
      end
    end
    start     = 1'b0;
    fifo_full = 1'b0;
    check("pkt_complete", {31'h0, last_done}, 32'h1);
    if (full_mode == 0) check("pkt_cycles", 32'(busy_cyc), 32'(len + 2));
    check("words_left", 32'(exp_q.size()), 32'h0);
    exp_ctr = exp_ctr + 32'(len);
    exp_seq = exp_seq + 16'd1;
    check("seq_after", {16'h0, seq}, {16'h0, exp_seq});
    check("ctr_after", ctr_val, exp_ctr);
  endtask

  // Directed and randomized sequence.
  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    pkt_len      = '0;
    fifo_full    = 1'b0;
    ctr_load     = 1'b0;
    ctr_load_val = 32'h0;
    ctr_val      = 32'h0;
    exp_ctr      = 32'h0;
    exp_seq      = 16'h0;

    // Reset state.
    repeat (2) @(negedge clk);
    start = 1'b1;
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_wr_en", {31'h0, fifo_wr_en}, 32'h0);
    check("rst_ctr_en", {31'h0, ctr_en}, 32'h0);
    check("rst_din", fifo_din, 32'h0);
    check("rst_seq", {16'h0, seq}, 32'h0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;

    // Basic 4-word packet from counter 0x10.
    load_ctr(32'h10);
    run_packet(4, 0, 1'b0);

    // Empty packet: header then zero trailer, counter untouched.
    run_packet(0, 0, 1'b0);

    // Backpressure right after the first data word.
    load_ctr(32'h5);
    run_packet(3, 2, 1'b0);

    // Start pulses while busy are ignored and not queued.
    run_packet(8, 0, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("start_not_queued", {31'h0, busy}, 32'h0);

    // Sequence wrap.
    @(negedge clk);
    force dut.seq_q = 16'hFFFF;
    @(negedge clk);
    release dut.seq_q;
    exp_seq = 16'hFFFF;
    run_packet(2, 0, 1'b0);

    // Randomized packets.
    load_ctr($urandom);
    for (int p = 0; p < 10; p++) begin
      run_packet(int'($urandom_range(0, 12)), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a packet.
    load_ctr(32'h100);
    @(negedge clk);
    start   = 1'b1;
    pkt_len = LEN_W'(8);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("pre_rst_busy", {31'h0, busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_wr_en", {31'h0, fifo_wr_en}, 32'h0);
    check("midrst_ctr_en", {31'h0, ctr_en}, 32'h0);
    check("midrst_din", fifo_din, 32'h0);
    check("midrst_seq", {16'h0, seq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("postrst_wr_en", {31'h0, fifo_wr_en}, 32'h0);
    exp_seq = 16'h0;
    load_ctr(32'h200);
    run_packet(3, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ctr_pkt_writer.md
CTR_PKT_WRITER -- requirements
Module: ctr_pkt_writer

Interface
REQ-001 Parameter HDR_MAGIC, default 16'hA5C3: upper half of every header word.
REQ-002 Parameter LEN_W, default 16: width of pkt_len and internal word counter.
REQ-003 clk  input  1: single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 start  input  1: request one packet; sampled only in IDLE.
REQ-006 pkt_len  input  LEN_W: number of data words; latched on accepted start.
REQ-007 ctr_val  input  32: current value of the upstream free-running counter.
REQ-008 ctr_en  output  1: advance request to the upstream counter, one pulse per data word consumed.
REQ-009 fifo_full  input  1: downstream FIFO full; no write is permitted while high.
REQ-010 fifo_wr_en  output  1: FIFO write strobe.
REQ-011 fifo_din  output  32: FIFO write data.
REQ-012 busy  output  1: high in every state except IDLE.
REQ-013 seq  output  16: sequence number of the next packet to be emitted.

Function
REQ-014 FSM states: IDLE, HEADER, DATA, TRAILER.
REQ-015 IDLE: on start=1, latch pkt_len and clear checksum, then go to HEADER. Otherwise stay in IDLE.
REQ-016 HEADER: emits {HDR_MAGIC, seq}. On a write cycle, go to DATA if latched length != 0, else to TRAILER.
REQ-017 DATA: emits ctr_val. On a write cycle:
  - checksum <= checksum ^ ctr_val;
  - word count increments;
  - after the last (pkt_len-th) write, go to TRAILER.
REQ-018 TRAILER: emits the checksum. On a write cycle:
  - seq increments, wrapping 16'hFFFF -> 16'h0000;
  - go to IDLE.
REQ-019 A write cycle is any cycle with state != IDLE and fifo_full=0. fifo_wr_en is combinationally high exactly in write cycles.
REQ-020 fifo_din is a combinational mux of the current state's word. It is 32'h0 in IDLE.
REQ-021 ctr_en = (state==DATA) & ~fifo_full, combinational. The upstream counter therefore advances only after its value is written, so data words are consecutive counter values with no gaps.
REQ-022 While fifo_full=1: state, counters, checksum and outputs other than fifo_wr_en/ctr_en hold; no word is lost or duplicated.
REQ-023 start while busy=1 is ignored and not queued. A new start in the cycle after returning to IDLE is accepted.
REQ-024 Changes to pkt_len after acceptance have no effect on the packet in flight.
REQ-025 Minimum packet time with fifo_full=0 is pkt_len+2 cycles after the start cycle, with one word per cycle.
REQ-026 pkt_len=0 produces header then trailer 32'h0.

Reset
REQ-027 rst_n=0 asynchronously forces: state=IDLE, seq=0, checksum=0, word count=0, latched length=0.
REQ-028 During reset, outputs are busy=0, fifo_wr_en=0, ctr_en=0, fifo_din=0.
REQ-029 Reset mid-packet abandons the packet; no trailer is written. After release, the block waits for a new start with seq=0.
REQ-030 Reset release is treated as synchronous to clk by the integrator; no internal synchroniser.

Structure
REQ-031 A shared package ctr_pkt_pkg holds the state enum and the default HDR_MAGIC constant.
REQ-032 Single flat module; no sub-module. The upstream counter is a sibling instance wired by the parent.

Verification
REQ-033 pkt_len=4, counter at 32'h10, fifo_full=0, pulse start:
  - writes A5C30000, 10, 11, 12, 13, then 00000000 (XOR of 10..13);
  - six consecutive cycles; seq becomes 1.
REQ-034 pkt_len=0, start: writes A5C30000 then 00000000; no ctr_en pulse.
REQ-035 pkt_len=3, counter at 32'h5, fifo_full=1 for 2 cycles after the first data word:
  - data exactly 5, 6, 7; no fifo_wr_en or ctr_en while full;
  - trailer 32'h4 (5^6^7).
REQ-036 start pulsed again during DATA of a pkt_len=8 packet: ignored; exactly one packet of 10 words.
REQ-037 Force seq=16'hFFFF, run one packet: header A5C3FFFF, seq reads 0 afterwards.
REQ-038 rst_n low during DATA of a pkt_len=8 packet:
  - outputs go to zero immediately, no trailer written;
  - next start emits header A5C30000.
